// File: rtl/demux_sched.sv
// demux_sched: credit-based round-robin scheduler for a 2-lane demux.
//
// Accepts one word per cycle from a valid/ready upstream source and steers it
// to lane 0 or lane 1. Each lane has a credit counter bounding its outstanding
// words; a lane with no credits is skipped in favour of the other one.
//
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   data_in, valid_in      upstream word and its valid
//   ready_in               block can accept data_in this cycle
//   credit_ret0/1          one-cycle credit return pulse per lane
//   data_out0/1            registered lane words (hold when not sent)
//   valid_out0/1           registered lane valids (one-cycle pulse per word)
//   credit0/1              credits available per lane
//   rr_ptr                 preferred lane for the next accepted word
//   cred_err               sticky: a credit was returned to a full counter
module demux_sched #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CREDITS = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic              credit_ret0,
    input  logic              credit_ret1,
    output logic [DATA_W-1:0] data_out0,
    output logic              valid_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_out1,
    output logic [CNT_W-1:0]  credit0,
    output logic [CNT_W-1:0]  credit1,
    output logic              rr_ptr,
    output logic              cred_err
);

    typedef enum logic [0:0] {StInit, StActive} state_e;

    localparam logic [CNT_W-1:0] CredMax = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] CredOne = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  credit0_q, credit0_d;
    logic [CNT_W-1:0]  credit1_q, credit1_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              cred_err_q, cred_err_d;
    logic [DATA_W-1:0] data_out0_q, data_out0_d;
    logic [DATA_W-1:0] data_out1_q, data_out1_d;
    logic              valid_out0_q, valid_out0_d;
    logic              valid_out1_q, valid_out1_d;

    logic active;
    logic has0, has1;
    logic accept;
    logic sel_lane;
    logic send0, send1;
    logic ret0, ret1;

    always_comb begin
        active   = (state_q == StActive);
        has0     = (credit0_q != '0);
        has1     = (credit1_q != '0);
        ready_in = active & (has0 | has1);
        accept   = valid_in & ready_in;
        // Preferred lane unless it is out of credits; ready_in guarantees the
        // other lane has credit whenever the preferred one does not.
        if (rr_ptr_q == 1'b0) begin
            sel_lane = has0 ? 1'b0 : 1'b1;
        end else begin
            sel_lane = has1 ? 1'b1 : 1'b0;
        end
        send0 = accept & ~sel_lane;
        send1 = accept & sel_lane;
        // Returns are ignored until the counters have been loaded.
        ret0  = credit_ret0 & active;
        ret1  = credit_ret1 & active;
    end

    always_comb begin
        state_d      = state_q;
        credit0_d    = credit0_q;
        credit1_d    = credit1_q;
        rr_ptr_d     = rr_ptr_q;
        cred_err_d   = cred_err_q;
        data_out0_d  = data_out0_q;
        data_out1_d  = data_out1_q;
        valid_out0_d = 1'b0;
        valid_out1_d = 1'b0;

        unique case (state_q)
            StInit: begin
                credit0_d = CredMax;
                credit1_d = CredMax;
                state_d   = StActive;
            end
            StActive: begin
                if (accept) begin
                    rr_ptr_d = ~sel_lane;
                end
                if (send0) begin
                    data_out0_d  = data_in;
                    valid_out0_d = 1'b1;
                end
                if (send1) begin
                    data_out1_d  = data_in;
                    valid_out1_d = 1'b1;
                end

                if (send0 && !ret0) begin
                    credit0_d = credit0_q - CredOne;
                end else if (ret0 && !send0) begin
                    if (credit0_q == CredMax) begin
                        cred_err_d = 1'b1;
                    end else begin
                        credit0_d = credit0_q + CredOne;
                    end
                end

                if (send1 && !ret1) begin
                    credit1_d = credit1_q - CredOne;
                end else if (ret1 && !send1) begin
                    if (credit1_q == CredMax) begin
                        cred_err_d = 1'b1;
                    end else begin
                        credit1_d = credit1_q + CredOne;
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StInit;
            credit0_q    <= '0;
            credit1_q    <= '0;
            rr_ptr_q     <= 1'b0;
            cred_err_q   <= 1'b0;
            data_out0_q  <= '0;
            data_out1_q  <= '0;
            valid_out0_q <= 1'b0;
            valid_out1_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit0_q    <= credit0_d;
            credit1_q    <= credit1_d;
            rr_ptr_q     <= rr_ptr_d;
            cred_err_q   <= cred_err_d;
            data_out0_q  <= data_out0_d;
            data_out1_q  <= data_out1_d;
            valid_out0_q <= valid_out0_d;
            valid_out1_q <= valid_out1_d;
        end
    end

    assign data_out0  = data_out0_q;
    assign data_out1  = data_out1_q;
    assign valid_out0 = valid_out0_q;
    assign valid_out1 = valid_out1_q;
    assign credit0    = credit0_q;
    assign credit1    = credit1_q;
    assign rr_ptr     = rr_ptr_q;
    assign cred_err   = cred_err_q;

endmodule

// File: doc/demux_sched.md
# demux_sched

Credit-based round-robin scheduler for the 2-lane 8-bit demux datapath. It accepts one word per cycle from an upstream valid/ready source and steers it to output lane 0 or 1. Each downstream lane has a credit counter that bounds its outstanding words. It sits between the upstream byte source and the two lane consumers, and replaces free-running demux steering with flow-controlled scheduling.

## Interface
- DATA_W, 8, data word width
- CREDITS, 4, initial and maximum credits per lane (1..7)
- CNT_W, 3, credit counter width; must hold CREDITS
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- data_in  input  DATA_W  upstream word
- valid_in  input  1  upstream word valid
- ready_in  output  1  block can accept data_in this cycle
- credit_ret0  input  1  one-cycle pulse; lane 0 returns one credit
- credit_ret1  input  1  one-cycle pulse; lane 1 returns one credit
- data_out0  output  DATA_W  lane 0 word, registered
- valid_out0  output  1  lane 0 word valid, registered
- data_out1  output  DATA_W  lane 1 word, registered
- valid_out1  output  1  lane 1 word valid, registered
- credit0  output  CNT_W  lane 0 credits available
- credit1  output  CNT_W  lane 1 credits available
- rr_ptr  output  1  preferred lane for the next accepted word
- cred_err  output  1  sticky; a credit was returned to a full counter

## Operation
- FSM states: INIT and ACTIVE.
- During reset: state=INIT, credit0=credit1=0, rr_ptr=0, data_out*=0, valid_out*=0, cred_err=0.
- INIT: lasts exactly 1 cycle. It loads credit0=credit1=CREDITS, then moves to ACTIVE. ready_in=0 in INIT.
- ACTIVE: ready_in = (credit0!=0) | (credit1!=0), decoded combinationally from registered state.
- An accept occurs when valid_in & ready_in.
- Lane choice on accept:
  - Target is lane rr_ptr if credit[rr_ptr]!=0.
  - Otherwise the target is the other lane.
  - rr_ptr then becomes the complement of the lane used.
- No accept: rr_ptr holds.
- Target lane: data_out<lane> <= data_in, valid_out<lane> <= 1, credit<lane> decrements by 1.
- Non-target lane: valid_out=0 and data_out holds its last value.
- Without an accept, both valid_out are 0 the next cycle.
- Credit update per lane, evaluated each cycle:
  - send only: -1
  - return only: +1
  - send and return in the same cycle: unchanged
- A return while the counter equals CREDITS and no send occurs on that lane:
  - The counter saturates at CREDITS.
  - cred_err sets and stays set until reset.
- credit_ret* pulses are ignored in INIT.
- valid_in with ready_in=0 is not consumed. Upstream must hold the word; the block does not buffer.
- Reset asserted mid-operation:
  - All state returns to reset values on that edge.
  - In-flight valid_out pulses are dropped.
  - Credits are reloaded via INIT.

## Timing
- Latency is 1 cycle: a word accepted at edge N appears on data_out/valid_out after edge N.
- Throughput is 1 word per cycle while any credit remains.
- First possible accept is the 2nd rising edge after reset deasserts (INIT edge, then ACTIVE).
- ready_in falls in the cycle after the edge that consumes the last credit of both lanes.
- A credit returned at edge N is usable by an accept at edge N+1.
- credit0/credit1/rr_ptr/cred_err are registered and change only on rising edges.

## Test plan
- Reset release with valid_in=1, data_in=0x11 held -> ready_in=0 for 1 cycle (INIT). Then 0x11 goes to lane 0 with valid_out0=1, and rr_ptr=1.
- Stream 0xA0,0xA1,0xA2,0xA3 with no returns, CREDITS=4 -> lane0 gets A0,A2 and lane1 gets A1,A3, alternating. credit0=credit1=2.
- Stream 8 words with no returns -> lanes alternate. ready_in=0 after the 8th accept with credit0=credit1=0. The 9th word is held and not output.
- credit0=0 and credit1=3 with rr_ptr=0, send 0x55 -> 0x55 goes to lane 1, credit1=2, rr_ptr=0.
- credit_ret0 pulse coincident with a lane-0 send at credit0=2 -> credit0 stays 2. credit_ret1 pulse at credit1=4 -> credit1=4 and cred_err=1, staying 1 until reset.
- Assert reset for one cycle mid-stream -> next cycle outputs are zero and credits are 0. INIT reloads credits to 4, and streaming resumes on lane 0.
